// File: rtl/sram_controller.sv
// SRAM controller: turns one 32-bit load/store from the pipeline MEM stage
// into two 16-bit SRAM accesses (low half-word, then high half-word), each
// held for WAIT_CYCLES+1 cycles, and freezes the pipeline via `ready` until done.
//
// Handshake: a request (mem_r_en or mem_w_en) is sampled only in IDLE. In that
// same cycle ready drops combinationally; ready stays low through both accesses
// and rises for exactly one cycle (DONE) when the access is complete. Request
// inputs seen in any other state are ignored. During reset ready is held at 1.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] word_q, word_d;
    logic [31:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        last_cycle;

    assign last_cycle  = (cnt_q == LAST_CNT);
    assign read_data   = rdata_q;
    assign dbg_state_o = state_q;

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            word_q  <= 17'd0;
            data_q  <= 32'd0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, hold counter, read capture and SRAM bus outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        data_d      = data_q;
        wr_d        = wr_q;
        rdata_d     = rdata_q;
        ready       = 1'b1;
        sram_addr   = 18'd0;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'd0;

        case (state_q)
            IDLE: begin
                if (mem_w_en || mem_r_en) begin
                    ready   = 1'b0;
                    // Word index wraps: only the low 17 bits reach the SRAM.
                    word_d  = 17'((address - BASE_ADDR) >> 2);
                    data_d  = write_data;
                    wr_d    = mem_w_en;  // write wins when both are requested
                    cnt_d   = 4'd0;
                    state_d = ACC_LO;
                end
            end
            ACC_LO: begin
                ready     = 1'b0;
                sram_addr = {word_q, 1'b0};
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[15:0];
                end
                if (last_cycle) begin
                    cnt_d   = 4'd0;
                    state_d = ACC_HI;
                    if (!wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ACC_HI: begin
                ready     = 1'b0;
                sram_addr = {word_q, 1'b1};
                if (wr_q) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = data_q[31:16];
                end
                if (last_cycle) begin
                    cnt_d   = 4'd0;
                    state_d = DONE;
                    if (!wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The pipeline is never frozen while reset is asserted.
        if (!reset) ready = 1'b1;
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller (WAIT_CYCLES=1, BASE_ADDR=1024) with a
// small edge-written SRAM model on the half-word bus.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_r_en, mem_w_en;
    logic [31:0] address, write_data;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(32'd1024)) dut (
        .clock       (clk),
        .reset       (reset),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // SRAM model: 64 half-words, indexed by the low address bits
    logic [15:0] mem [64];
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    end
    assign sram_dq_in = mem[sram_addr[5:0]];

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_lo;
        logic [17:0] exp_hi;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        mem_r_en   = 1'b0;
        mem_w_en   = 1'b0;
        address    = 32'd0;
        write_data = 32'd0;
    endtask

    // One full transaction: request in cycle 0, DONE in cycle 5, idle in cycle 6.
    task automatic run_txn(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        mem_r_en = v.rd; mem_w_en = v.wr; address = v.addr; write_data = v.wdata;
        @(negedge clk);
        check({tag, " c0 ready"}, 32'(ready), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive_idle();
            @(negedge clk);
            check($sformatf("%s c%0d addr", tag, c), 32'(sram_addr), 32'((c <= 2) ? v.exp_lo : v.exp_hi));
            check($sformatf("%s c%0d we_n", tag, c), 32'(sram_we_n), 32'(!v.wr));
            check($sformatf("%s c%0d oe", tag, c), 32'(sram_dq_oe), 32'(v.wr));
            check($sformatf("%s c%0d ready", tag, c), 32'(ready), 32'd0);
            if (v.wr)
                check($sformatf("%s c%0d dq_out", tag, c), 32'(sram_dq_out),
                      32'((c <= 2) ? v.wdata[15:0] : v.wdata[31:16]));
        end
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " c5 ready"}, 32'(ready), 32'd1);
        check({tag, " c5 read_data"}, read_data, v.exp_rdata);
        check({tag, " c5 addr"}, 32'(sram_addr), 32'd0);
        check({tag, " c5 we_n"}, 32'(sram_we_n), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, " c6 ready"}, 32'(ready), 32'd1);
        check({tag, " c6 state"}, 32'(dbg_state), 32'd0);
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[5] = 16'h7777;

        //            rd    wr    addr         wdata          lo         hi         rdata
        vecs[0] = '{1'b0, 1'b1, 32'd1028,    32'hDEADBEEF, 18'h00002, 18'h00003, 32'h00000000};
        vecs[1] = '{1'b1, 1'b0, 32'd1028,    32'h00000000, 18'h00002, 18'h00003, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b1, 32'd1024,    32'h12345678, 18'h00000, 18'h00001, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 1'b0, 32'd1024,    32'h00000000, 18'h00000, 18'h00001, 32'h12345678};
        vecs[4] = '{1'b0, 1'b1, 32'd1020,    32'hCAFEF00D, 18'h3FFFE, 18'h3FFFF, 32'h12345678};
        vecs[5] = '{1'b1, 1'b0, 32'd1020,    32'h00000000, 18'h3FFFE, 18'h3FFFF, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b1, 32'd1031,    32'hA5A55A5A, 18'h00002, 18'h00003, 32'hCAFEF00D};
        vecs[7] = '{1'b1, 1'b0, 32'd1029,    32'h00000000, 18'h00002, 18'h00003, 32'hA5A55A5A};
        vecs[8] = '{1'b1, 1'b0, 32'h00080400, 32'h00000000, 18'h00000, 18'h00001, 32'h12345678};

        // reset held low, inputs idle
        reset = 1'b0;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst ready", 32'(ready), 32'd1);
        check("rst read_data", read_data, 32'd0);
        check("rst we_n", 32'(sram_we_n), 32'd1);
        check("rst oe", 32'(sram_dq_oe), 32'd0);
        check("rst addr", 32'(sram_addr), 32'd0);
        check("rst dq_out", 32'(sram_dq_out), 32'd0);
        mem_w_en = 1'b1;
        #1;
        check("rst ready with request", 32'(ready), 32'd1);
        mem_w_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // table-driven transactions
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], i);
            if (i == 2) begin
                check("both: mem[0]", 32'(mem[0]), 32'h5678);
                check("both: mem[1]", 32'(mem[1]), 32'h1234);
            end
        end

        // request held through DONE, inputs changed mid-access, new read at cycle 6
        @(posedge clk); #1;
        mem_r_en = 1'b1; address = 32'd1028;
        @(negedge clk);
        check("hold c0 ready", 32'(ready), 32'd0);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 2) begin
                address = 32'd1040; mem_w_en = 1'b1; write_data = 32'h0BADF00D;
            end
            @(negedge clk);
            check($sformatf("hold c%0d addr", c), 32'(sram_addr), (c <= 2) ? 32'd2 : 32'd3);
            check($sformatf("hold c%0d we_n", c), 32'(sram_we_n), 32'd1);
        end
        @(posedge clk); #1;
        address = 32'd1024; mem_w_en = 1'b0; write_data = 32'd0;
        @(negedge clk);
        check("hold c5 ready", 32'(ready), 32'd1);
        check("hold c5 read_data", read_data, 32'hA5A55A5A);
        check("hold c5 state", 32'(dbg_state), 32'd3);
        check("hold mem[2] untouched", 32'(mem[2]), 32'h5A5A);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold c6 ready", 32'(ready), 32'd0);
        check("hold c6 state", 32'(dbg_state), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold c7 state", 32'(dbg_state), 32'd1);
        check("hold c7 addr", 32'(sram_addr), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hold c10 addr", 32'(sram_addr), 32'd1);
        @(posedge clk); #1;
        mem_r_en = 1'b0; address = 32'd0;
        @(negedge clk);
        check("hold c11 ready", 32'(ready), 32'd1);
        check("hold c11 read_data", read_data, 32'h12345678);
        @(posedge clk); #1;
        @(negedge clk);
        check("hold c12 ready", 32'(ready), 32'd1);
        check("hold c12 state", 32'(dbg_state), 32'd0);

        // reset pulsed in cycle 3 of a write
        @(posedge clk); #1;
        mem_w_en = 1'b1; address = 32'd1032; write_data = 32'h11112222;
        @(negedge clk);
        check("abort c0 ready", 32'(ready), 32'd0);
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            if (c == 1) drive_idle();
            @(negedge clk);
            check($sformatf("abort c%0d addr", c), 32'(sram_addr), 32'd4);
            check($sformatf("abort c%0d we_n", c), 32'(sram_we_n), 32'd0);
        end
        @(posedge clk); #1;
        check("abort c3 we_n before reset", 32'(sram_we_n), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("abort we_n", 32'(sram_we_n), 32'd1);
        check("abort ready", 32'(ready), 32'd1);
        check("abort oe", 32'(sram_dq_oe), 32'd0);
        check("abort addr", 32'(sram_addr), 32'd0);
        check("abort read_data", read_data, 32'd0);
        check("abort state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("abort after state", 32'(dbg_state), 32'd0);
        check("abort after we_n", 32'(sram_we_n), 32'd1);
        check("abort mem[4]", 32'(mem[4]), 32'h2222);
        check("abort mem[5]", 32'(mem[5]), 32'h7777);
        v = '{1'b1, 1'b0, 32'd1032, 32'h00000000, 18'h00004, 18'h00005, 32'h77772222};
        run_txn(v, 99);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra hold cycles per SRAM half-word access (legal range 0..15).
REQ-002 SHALL have parameter BASE_ADDR, default 1024: byte address mapped to SRAM word 0.
REQ-003 SHALL have port clock  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_r_en  in  1  load request from the pipeline MEM stage.
REQ-006 SHALL have port mem_w_en  in  1  store request from the pipeline MEM stage.
REQ-007 SHALL have port address  in  32  byte address (ALU result); bits [1:0] ignored.
REQ-008 SHALL have port write_data  in  32  store value (ST value).
REQ-009 SHALL have port read_data  out  32  registered load result returned to the pipeline.
REQ-010 SHALL have port ready  out  1  high = request complete or no request; low = freeze the pipeline.
REQ-011 SHALL have port sram_addr  out  18  SRAM half-word address.
REQ-012 SHALL have port sram_dq_out  out  16  SRAM write data.
REQ-013 SHALL have port sram_dq_oe  out  1  high = controller drives the SRAM data bus.
REQ-014 SHALL have port sram_dq_in  in  16  SRAM read data.
REQ-015 SHALL have port sram_we_n  out  1  active-low SRAM write strobe.

Function
REQ-016 SHALL implement FSM states IDLE, ACC_LO, ACC_HI, DONE.
REQ-017 SHALL compute word = (address - BASE_ADDR) mod 2^32 >> 2; sram_addr = {word[16:0], 0} in ACC_LO and {word[16:0], 1} in ACC_HI; word bits above [16] are discarded (wrap).
REQ-018 In IDLE with mem_w_en or mem_r_en high, SHALL drive ready = 0 combinationally in that same cycle, latch address, write_data and the operation, and go to ACC_LO.
REQ-019 If mem_w_en and mem_r_en are both high, SHALL perform the write only; read_data is unchanged.
REQ-020 ACC_LO and ACC_HI SHALL each last exactly WAIT_CYCLES+1 cycles, counted by an internal counter cleared on entry.
REQ-021 During a write access SHALL drive sram_we_n = 0 and sram_dq_oe = 1 for the whole state; sram_dq_out = data[15:0] in ACC_LO and data[31:16] in ACC_HI.
REQ-022 During a read access SHALL hold sram_we_n = 1 and sram_dq_oe = 0, and SHALL capture sram_dq_in on the last cycle of the state: into read_data[15:0] in ACC_LO, into read_data[31:16] in ACC_HI.
REQ-023 DONE SHALL last one cycle with ready = 1, SHALL ignore the still-asserted request, and SHALL return to IDLE.
REQ-024 Request-to-ready latency SHALL be 2*WAIT_CYCLES+3 cycles, counting the request cycle as 0; ready is 0 in cycles 0..2*WAIT_CYCLES+2.
REQ-025 read_data SHALL hold its value between reads and SHALL be complete and valid from the DONE cycle onward.
REQ-026 In IDLE and DONE SHALL drive sram_addr = 0, sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
REQ-027 Request inputs SHALL be sampled only in IDLE; changes in other states have no effect.

Reset
REQ-028 reset low SHALL immediately force state IDLE, counter 0, read_data 0, sram_we_n 1, sram_dq_oe 0, sram_addr 0 and sram_dq_out 0, independent of clock.
REQ-029 ready SHALL be 1 during reset and SHALL follow REQ-018 after reset is released.
REQ-030 A reset that arrives mid-access SHALL abort the access, and no partial write is resumed afterwards.

Verification (WAIT_CYCLES=1, BASE_ADDR=1024)
REQ-031 Reset held low, all inputs 0 -> ready=1, read_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0.
REQ-032 Write of 0xDEADBEEF at address 1028 -> cycles 1-2: sram_addr=2, dq_out=0xBEEF, we_n=0; cycles 3-4: sram_addr=3, dq_out=0xDEAD, we_n=0; ready=1 only in cycle 5.
REQ-033 Read at 1028 with an SRAM model holding the REQ-032 data -> read_data=0xDEADBEEF in cycle 5, we_n=1 and dq_oe=0 throughout.
REQ-034 mem_r_en=mem_w_en=1 at 1024 with data 0x12345678 -> SRAM half-words 0/1 = 0x5678/0x1234, read_data unchanged.
REQ-035 reset pulsed low in cycle 3 of a write -> we_n=1 and ready=1 asynchronously; half-word 1 is never written; the next request starts cleanly from IDLE.
REQ-036 Request held high through DONE followed by a new read in cycle 6 -> no re-execution in DONE; the new access begins with ready=0 in cycle 6.
